// File: rtl/dp_types_pkg.sv
// ---------------------------------------------------------------------------
// dp_types_pkg
//   Shared datapath types for the 5-stage pipelined CPU.
//   - word_t        : 32-bit machine word
//   - IF_ID_t       : IF/ID pipeline latch {imemload, pc, pc4}
//   - fetch_state_t : fetch-stage controller states
//   - pc_sel_t      : next-PC source select driven into pc_unit
//   - ifid_op_t     : per-cycle action applied to the IF/ID latch
//   - PC_STEP       : sequential PC increment
//   - ALIGN_MASK    : clears the byte-offset bits of an instruction address
// ---------------------------------------------------------------------------
package dp_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t imemload;
    word_t pc;
    word_t pc4;
  } IF_ID_t;

  typedef enum logic [1:0] {
    FETCH_RUN  = 2'd0,
    FETCH_HELD = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    IFID_KEEP      = 2'd0,
    IFID_BUBBLE    = 2'd1,
    IFID_LOAD_MEM  = 2'd2,
    IFID_LOAD_HELD = 2'd3
  } ifid_op_t;

  localparam word_t PC_STEP    = 32'd4;
  localparam word_t ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_stage_pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
//   Program counter register with next-PC mux (hold / PC+4 / redirect).
//   Redirect targets are forced word aligned before they are stored, so the
//   PC never carries a byte offset.
// Ports
//   CLK          in   clock, rising edge
//   nRST         in   asynchronous active-low reset (PC <= PC_INIT)
//   pc_sel       in   next-PC source
//   redirect_pc  in   redirect target (bits [1:0] ignored)
//   pc           out  current PC
//   pc4          out  PC + 4 (wraps mod 2^32)
// ---------------------------------------------------------------------------
module pc_unit
  import dp_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic    CLK,
  input  logic    nRST,
  input  pc_sel_t pc_sel,
  input  word_t   redirect_pc,
  output word_t   pc,
  output word_t   pc4
);

  assign pc4 = pc + PC_STEP;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc <= PC_INIT;
    end else begin
      case (pc_sel)
        PC_INC:      pc <= pc4;
        PC_REDIRECT: pc <= redirect_pc & ALIGN_MASK;
        default:     pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the PC (via pc_unit), issues icache reads,
//   and fills the IF/ID latch. Honours hazard stall/flush, downstream
//   redirects and halt. Per-cycle priority: halt > redirect > flush > stall.
//   A word returned while stalled is parked in a hold buffer (FETCH_HELD) and
//   delivered one cycle after the stall releases, without refetching.
// Optional feature: define FETCH_PERF_EN to add saturating performance
//   counters perf_fetch_o / perf_stall_o.
// Ports
//   CLK, nRST      clock / asynchronous active-low reset
//   ihit, imemload icache hit and instruction word
//   imemREN        icache read request (1 only in FETCH_RUN)
//   imemaddr       icache address = word-aligned PC
//   stall_i        hold IF/ID and PC
//   flush_i        squash IF/ID to a bubble
//   redirect_i     redirect PC to redirect_pc_i
//   halt_i         stop fetching until reset
//   ifid_o         IF/ID latch
//   ifid_valid_o   IF/ID holds a real instruction
//   perf_fetch_o   (FETCH_PERF_EN) valid IF/ID writes
//   perf_stall_o   (FETCH_PERF_EN) icache-miss cycles plus FETCH_HELD cycles
// ---------------------------------------------------------------------------
module fetch_stage
  import dp_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic   CLK,
  input  logic   nRST,
  input  logic   ihit,
  input  word_t  imemload,
  output logic   imemREN,
  output word_t  imemaddr,
  input  logic   stall_i,
  input  logic   flush_i,
  input  logic   redirect_i,
  input  word_t  redirect_pc_i,
  input  logic   halt_i,
  output IF_ID_t ifid_o,
  output logic   ifid_valid_o
`ifdef FETCH_PERF_EN
  ,
  output word_t  perf_fetch_o,
  output word_t  perf_stall_o
`endif
);

  fetch_state_t state;
  fetch_state_t state_d;
  pc_sel_t      pc_sel;
  ifid_op_t     ifid_op;
  logic         hold_load;
  word_t        held_word;
  word_t        pc;
  word_t        pc4;

  pc_unit #(.PC_INIT(PC_INIT)) u_pc_unit (
    .CLK         (CLK),
    .nRST        (nRST),
    .pc_sel      (pc_sel),
    .redirect_pc (redirect_pc_i),
    .pc          (pc),
    .pc4         (pc4)
  );

  assign imemREN  = (state == FETCH_RUN);
  assign imemaddr = pc & ALIGN_MASK;

  // NOTE: every signal driven here gets a default first, so no path through
  // the decode can leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    pc_sel    = PC_HOLD;
    ifid_op   = IFID_KEEP;
    hold_load = 1'b0;
    if (state == FETCH_HALT) begin
      ifid_op = IFID_BUBBLE;
    end else if (halt_i) begin
      state_d = FETCH_HALT;
      ifid_op = IFID_BUBBLE;
    end else if (redirect_i) begin
      // Any in-flight or parked word is from the wrong path; IF/ID is left
      // to flush_i.
      pc_sel  = PC_REDIRECT;
      state_d = FETCH_RUN;
      if (flush_i) ifid_op = IFID_BUBBLE;
    end else if (state == FETCH_RUN) begin
      if (flush_i) begin
        // Fetched word is on the correct path; only the latch is squashed.
        ifid_op = IFID_BUBBLE;
        if (ihit) pc_sel = PC_INC;
      end else if (stall_i) begin
        if (ihit) begin
          hold_load = 1'b1;
          state_d   = FETCH_HELD;
        end
      end else if (ihit) begin
        ifid_op = IFID_LOAD_MEM;
        pc_sel  = PC_INC;
      end else begin
        ifid_op = IFID_BUBBLE;
      end
    end else begin
      // FETCH_HELD: the parked word is consumed by a release or a flush.
      if (flush_i) begin
        ifid_op = IFID_BUBBLE;
        pc_sel  = PC_INC;
        state_d = FETCH_RUN;
      end else if (!stall_i) begin
        ifid_op = IFID_LOAD_HELD;
        pc_sel  = PC_INC;
        state_d = FETCH_RUN;
      end
    end
  end

  // NOTE: the hold buffer is a single data register, reset alongside the
  // control state so the stage powers up fully deterministic.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= FETCH_RUN;
      held_word    <= '0;
      ifid_o       <= '0;
      ifid_valid_o <= 1'b0;
    end else begin
      state <= state_d;
      if (hold_load) held_word <= imemload;
      case (ifid_op)
        IFID_BUBBLE: begin
          ifid_o       <= '0;
          ifid_valid_o <= 1'b0;
        end
        IFID_LOAD_MEM: begin
          ifid_o       <= '{imemload: imemload, pc: pc, pc4: pc4};
          ifid_valid_o <= 1'b1;
        end
        IFID_LOAD_HELD: begin
          ifid_o       <= '{imemload: held_word, pc: pc, pc4: pc4};
          ifid_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic fetch_evt;
  logic stall_evt;

  assign fetch_evt = (ifid_op == IFID_LOAD_MEM) || (ifid_op == IFID_LOAD_HELD);
  assign stall_evt = ((state == FETCH_RUN) && !ihit) || (state == FETCH_HELD);

  // Counters saturate at all-ones; neither event can occur in FETCH_HALT.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_fetch_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (fetch_evt && (perf_fetch_o != '1)) perf_fetch_o <= perf_fetch_o + 32'd1;
      if (stall_evt && (perf_stall_o != '1)) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage: directed scenarios followed by a
//   randomized run, all compared against a behavioural model of the fetch
//   rules (PC, IF/ID contents and a queue for a parked instruction).
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  import dp_types_pkg::*;

  localparam word_t PC_INIT = 32'h0000_0000;

  logic   CLK = 1'b0;
  logic   nRST;
  logic   ihit;
  word_t  imemload;
  logic   imemREN;
  word_t  imemaddr;
  logic   stall_i;
  logic   flush_i;
  logic   redirect_i;
  word_t  redirect_pc_i;
  logic   halt_i;
  IF_ID_t ifid_o;
  logic   ifid_valid_o;
`ifdef FETCH_PERF_EN
  word_t  perf_fetch_o;
  word_t  perf_stall_o;
`endif

  fetch_stage #(.PC_INIT(PC_INIT)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ihit          (ihit),
    .imemload      (imemload),
    .imemREN       (imemREN),
    .imemaddr      (imemaddr),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .ifid_o        (ifid_o),
    .ifid_valid_o  (ifid_valid_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  // Behavioural model state.
  word_t m_pc;
  word_t m_load;
  word_t m_ipc;
  word_t m_ipc4;
  bit    m_valid;
  bit    m_halted;
  word_t m_held[$];
  int    m_fetch_cnt;
  int    m_stall_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc        = PC_INIT;
    m_load      = '0;
    m_ipc       = '0;
    m_ipc4      = '0;
    m_valid     = 1'b0;
    m_halted    = 1'b0;
    m_held.delete();
    m_fetch_cnt = 0;
    m_stall_cnt = 0;
  endtask

  // Writes a real instruction into the model latch and advances the PC.
  task automatic model_deliver(input word_t w);
    m_load  = w;
    m_ipc   = m_pc;
    m_ipc4  = m_pc + 32'd4;
    m_valid = 1'b1;
    m_pc    = m_pc + 32'd4;
    m_fetch_cnt++;
  endtask

  task automatic model_step(input logic ih, input word_t ld, input logic st,
                            input logic fl, input logic rd, input word_t rpc,
                            input logic hl);
    if (!m_halted && (m_held.size() != 0 || !ih)) m_stall_cnt++;
    if (m_halted) begin
      m_valid = 1'b0;
    end else if (hl) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
      m_held.delete();
    end else if (rd) begin
      m_pc = {rpc[31:2], 2'b00};
      m_held.delete();
      if (fl) m_valid = 1'b0;
    end else if (fl) begin
      m_valid = 1'b0;
      if (m_held.size() != 0) begin
        m_held.delete();
        m_pc = m_pc + 32'd4;
      end else if (ih) begin
        m_pc = m_pc + 32'd4;
      end
    end else if (m_held.size() != 0) begin
      if (!st) model_deliver(m_held.pop_front());
    end else if (st) begin
      if (ih) m_held.push_back(ld);
    end else if (ih) begin
      model_deliver(ld);
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare();
    check("imemREN", {31'd0, imemREN}, {31'd0, !m_halted && m_held.size() == 0});
    check("imemaddr", imemaddr, m_pc);
    check("valid", {31'd0, ifid_valid_o}, {31'd0, m_valid});
    if (m_valid) begin
      check("ifid.imemload", ifid_o.imemload, m_load);
      check("ifid.pc", ifid_o.pc, m_ipc);
      check("ifid.pc4", ifid_o.pc4, m_ipc4);
    end
`ifdef FETCH_PERF_EN
    check("perf_fetch", perf_fetch_o, m_fetch_cnt);
    check("perf_stall", perf_stall_o, m_stall_cnt);
`endif
  endtask

  // One clock: drive at the negedge, update the model, sample at the next negedge.
  task automatic cyc(input logic ih, input word_t ld, input logic st, input logic fl,
                     input logic rd, input word_t rpc, input logic hl);
    ihit          = ih;
    imemload      = ld;
    stall_i       = st;
    flush_i       = fl;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    halt_i        = hl;
    model_step(ih, ld, st, fl, rd, rpc, hl);
    @(posedge CLK);
    @(negedge CLK);
    compare();
  endtask

  initial begin
    nRST = 1'b0;
    ihit = 1'b0; imemload = '0; stall_i = 1'b0; flush_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0;
    model_reset();

    // Reset state.
    #1;
    check("rst imemREN", {31'd0, imemREN}, 32'd1);
    check("rst imemaddr", imemaddr, PC_INIT);
    check("rst valid", {31'd0, ifid_valid_o}, 32'd0);
    check("rst ifid.imemload", ifid_o.imemload, 32'd0);
    check("rst ifid.pc", ifid_o.pc, 32'd0);
    check("rst ifid.pc4", ifid_o.pc4, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // 1: continuous hits, PC steps by 4.
    cyc(1, 32'h2001_0005, 0, 0, 0, 0, 0);
    check("t1 pc", ifid_o.pc, 32'h0);
    check("t1 pc4", ifid_o.pc4, 32'h4);
    check("t1 valid", {31'd0, ifid_valid_o}, 32'd1);
    check("t1 addr", imemaddr, 32'h4);
    for (int i = 0; i < 3; i++) cyc(1, 32'h2001_0005, 0, 0, 0, 0, 0);

    // 2: three misses at 0x10.
    for (int i = 0; i < 3; i++) cyc(0, $urandom, 0, 0, 0, 0, 0);
    check("t2 addr", imemaddr, 32'h10);
    check("t2 valid", {31'd0, ifid_valid_o}, 32'd0);
`ifdef FETCH_PERF_EN
    check("t2 perf_stall", perf_stall_o, 32'd3);
`endif
    for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 0, 0, 0, 0);

    // 3: hit under stall at 0x20, stall held two cycles, then release.
    cyc(1, 32'hAC22_0004, 1, 0, 0, 0, 0);
    check("t3 ren held", {31'd0, imemREN}, 32'd0);
    cyc(1, $urandom, 1, 0, 0, 0, 0);
    cyc(1, $urandom, 0, 0, 0, 0, 0);
    check("t3 imemload", ifid_o.imemload, 32'hAC22_0004);
    check("t3 pc", ifid_o.pc, 32'h20);
    check("t3 pc4", ifid_o.pc4, 32'h24);
    check("t3 addr", imemaddr, 32'h24);

    // 4: redirect + flush while a word is parked.
    cyc(1, 32'h1234_5678, 1, 0, 0, 0, 0);
    cyc(1, $urandom, 1, 1, 1, 32'h0000_0103, 0);
    check("t4 valid", {31'd0, ifid_valid_o}, 32'd0);
    check("t4 addr", imemaddr, 32'h100);
    cyc(1, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
    check("t4 pc", ifid_o.pc, 32'h100);

    // 5: PC wrap at the top of the address space.
    cyc(0, $urandom, 0, 0, 1, 32'hFFFF_FFFC, 0);
    cyc(1, 32'h0000_0020, 0, 0, 0, 0, 0);
    check("t5 pc4", ifid_o.pc4, 32'h0);
    check("t5 addr", imemaddr, 32'h0);

    // Randomized traffic (no halt).
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, $urandom, 1'b0);

    // 6: halt wins over stall and redirect; only reset exits.
    cyc(1, $urandom, 1, 0, 1, 32'h0000_0400, 1);
    for (int i = 0; i < 5; i++)
      cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    check("t6 ren halted", {31'd0, imemREN}, 32'd0);
    #2 nRST = 1'b0;
    #1;
    model_reset();
    check("t6 rst imemREN", {31'd0, imemREN}, 32'd1);
    check("t6 rst addr", imemaddr, PC_INIT);
    check("t6 rst valid", {31'd0, ifid_valid_o}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    cyc(1, 32'h2001_0005, 0, 0, 0, 0, 0);
    cyc(1, 32'h2001_0006, 0, 0, 0, 0, 0);
    check("t6 post addr", imemaddr, PC_INIT + 32'd8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
